// File: rtl/alu_issue.sv
// Single-issue RV32I OP/OP-IMM sequencer: decodes one instruction, drives an external
// combinational ALU, and writes the result back into a 31-entry register file.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  output logic [31:0] ra_d,
  output logic [31:0] rb_d,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        imm_t,
  input  logic [31:0] rd_d,
  output logic        retire,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  state_e      state_q, state_d;
  logic [31:0] ra_q, ra_nx, rb_q, rb_nx, res_q, res_d;
  logic [2:0]  f3_q, f3_d;
  logic [6:0]  f7_q, f7_d;
  logic        imm_q, imm_d, legal_q, legal_d, retire_q, retire_d, illegal_q, illegal_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  // Entry 0 is never written, so it stays at its reset value of zero.
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [6:0]  opcode, in_f7;
  logic [2:0]  in_f3;
  logic [4:0]  rs1, rs2;
  logic        accept, op_legal, opi_legal, dec_legal;

  assign opcode = inst[6:0];
  assign in_f3  = inst[14:12];
  assign in_f7  = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign inst_ready = rst_n && (state_q == StIdle);
  assign accept     = inst_valid && inst_ready;

  assign ra_d     = ra_q;
  assign rb_d     = rb_q;
  assign func3    = f3_q;
  assign func7    = f7_q;
  assign imm_t    = imm_q;
  assign retire   = retire_q;
  assign illegal  = illegal_q;
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

  always_comb begin
    op_legal  = (in_f7 == 7'd0) || ((in_f7 == F7Alt) && (in_f3 == 3'b000 || in_f3 == 3'b101));
    opi_legal = 1'b1;
    if (in_f3 == 3'b001) begin
      opi_legal = (in_f7 == 7'd0);
    end else if (in_f3 == 3'b101) begin
      opi_legal = (in_f7 == 7'd0) || (in_f7 == F7Alt);
    end
    dec_legal = ((opcode == OpcOp) && op_legal) || ((opcode == OpcOpImm) && opi_legal);
  end

  always_comb begin
    state_d   = state_q;
    ra_nx     = ra_q;
    rb_nx     = rb_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    imm_d     = imm_q;
    legal_d   = legal_q;
    rd_idx_d  = rd_idx_q;
    res_d     = res_q;
    retire_d  = retire_q;
    illegal_d = illegal_q;
    rf_d      = rf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StExec;
          legal_d  = dec_legal;
          rd_idx_d = inst[11:7];
          // Illegal instructions leave the ALU-facing outputs untouched.
          if (dec_legal) begin
            ra_nx = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
            f3_d  = in_f3;
            f7_d  = in_f7;
            if (opcode == OpcOp) begin
              rb_nx = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
              imm_d = 1'b0;
            end else begin
              rb_nx = {{20{inst[31]}}, inst[31:20]};
              imm_d = 1'b1;
            end
          end
        end
      end
      StExec: begin
        res_d     = rd_d;
        state_d   = StWb;
        retire_d  = legal_q;
        illegal_d = !legal_q;
      end
      StWb: begin
        state_d   = StIdle;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        if (legal_q && rd_idx_q != 5'd0) begin
          rf_d[rd_idx_q] = res_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ra_q      <= '0;
      rb_q      <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      imm_q     <= 1'b0;
      legal_q   <= 1'b0;
      rd_idx_q  <= '0;
      res_q     <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_nx;
      rb_q      <= rb_nx;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      imm_q     <= imm_d;
      legal_q   <= legal_d;
      rd_idx_q  <= rd_idx_d;
      res_q     <= res_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      rf_q      <= rf_d;
    end
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port inst, input, 32 bits: RV32I instruction word.
REQ-004 SHALL have port inst_valid, input, 1 bit: inst holds an instruction.
REQ-005 SHALL have port inst_ready, output, 1 bit: block accepts inst this cycle.
REQ-006 SHALL have ports ra_d and rb_d, outputs, 32 bits each: ALU operands.
REQ-007 SHALL have ports func3 (3 bits), func7 (7 bits) and imm_t (1 bit), outputs: ALU operation select.
REQ-008 SHALL have port rd_d, input, 32 bits: combinational ALU result for the driven operands.
REQ-009 SHALL have port retire, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-010 SHALL have port illegal, output, 1 bit: one-cycle pulse when an accepted instruction is rejected.
REQ-011 SHALL have ports dbg_addr (input, 5 bits) and dbg_data (output, 32 bits): combinational register-file read; x0 reads 0.

Function
REQ-012 SHALL hold 31 writable 32-bit registers x1..x31; x0 SHALL read 0 and ignore writes.
REQ-013 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; inst_ready SHALL be 1 only in IDLE.
REQ-014 Handshake: accept SHALL occur when inst_valid && inst_ready; IDLE without accept SHALL stay IDLE.
REQ-015 On accept, opcode 0110011 (OP) SHALL latch ra_d=x[rs1], rb_d=x[rs2], func3=inst[14:12], func7=inst[31:25], imm_t=0.
REQ-016 On accept, opcode 0010011 (OP-IMM) SHALL latch ra_d=x[rs1], rb_d=sign-extended inst[31:20], func3=inst[14:12], func7=inst[31:25], imm_t=1.
REQ-017 For OP-IMM shifts, rb_d[4:0] SHALL equal shamt inst[24:20]; upper bits follow the sign extension of REQ-016.
REQ-018 Legality: OP func7 SHALL be 0000000, or 0100000 only with func3 000/101; SLLI func7 SHALL be 0000000; SRLI/SRAI func7 SHALL be 0000000 or 0100000.
REQ-019 Any other opcode or func7 combination SHALL be illegal: FSM goes to WB with no register write and illegal=1 in WB instead of retire.
REQ-020 In EXEC, ALU control and operand outputs SHALL stay stable; rd_d SHALL be captured into a result register at the end of EXEC.
REQ-021 In WB, a legal instruction SHALL write the captured result to x[rd] (rd=inst[11:7]) at the end of the cycle, and retire SHALL be 1 for exactly that cycle.
REQ-022 Latency: accept at edge T, EXEC in cycle T+1, WB in cycle T+2, inst_ready high again in cycle T+3; throughput one instruction per 3 cycles.
REQ-023 Back-to-back dependency: the instruction after a retire SHALL read the updated register value; no forwarding is needed because operand read occurs in IDLE after writeback.
REQ-024 dbg_data SHALL reflect a WB write from the cycle after the write edge.
REQ-025 ALU outputs in IDLE SHALL hold the last latched values; inst SHALL be ignored outside the accept cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, ra_d=rb_d=0, func3=0, func7=0, imm_t=0, retire=0, illegal=0, and all registers x1..x31=0.
REQ-027 inst_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-028 Reset asserted in EXEC or WB SHALL abort the instruction with no register write and no retire or illegal pulse.

Verification
REQ-029 ADDI x1,x0,5 (0x00500093) -> ra_d=0, rb_d=5, imm_t=1 in EXEC; retire in WB; dbg x1=5.
REQ-030 After x1=5 and x2=-3 (ADDI 0xFFD00113), SUB x3,x1,x2 -> func7=0100000; x3=8; SLT x4,x2,x1 -> x4=1; SLTU x5,x2,x1 -> x5=0.
REQ-031 SRAI x6,x2,1 (func7=0100000, shamt=1) -> rb_d[4:0]=1; x6=0xFFFFFFFE.
REQ-032 ADDI x0,x0,7 -> retire pulses; dbg x0 reads 0.
REQ-033 Opcode 0x0000007F, then OP with func7=0000001 -> illegal pulses in the WB cycle, no retire, register file unchanged.
REQ-034 Reset asserted mid-EXEC of ADDI x7,x0,9 -> x7 stays 0, no retire, inst_ready=1 in the first cycle after release.
